// File: rtl/eightbit_mem_if.sv
// Bus bundle between the eightbit core side (CPU bus, program loader,
// output consumer) and the memory-side responder.
interface eightbit_mem_if;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;
    logic       cpu_en;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       ovf;

    modport master (
        output addr, wdata, we, ld_valid, ld_data, ld_last, out_ready,
        input  rdata, cpu_en, ld_ready, out_valid, out_data, ovf
    );

    modport slave (
        input  addr, wdata, we, ld_valid, ld_data, ld_last, out_ready,
        output rdata, cpu_en, ld_ready, out_valid, out_data, ovf
    );
endinterface

// File: rtl/eightbit_mem.sv
// Memory-side responder for the eightbit core: 256x8 RAM with a registered
// read port, a streamed program loader that gates the core through cpu_en,
// and one memory-mapped output port backed by a small FIFO.
module eightbit_mem #(
    parameter logic [7:0] IO_ADDR     = 8'hFF,
    parameter int         OFIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    eightbit_mem_if.slave  bus
);
    localparam int PTR_W = $clog2(OFIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OFIFO_DEPTH);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [7:0]       ptr_q, ptr_d;
    logic             ld_ready_q, ld_ready_d;
    logic [7:0]       rdata_q;
    logic             ovf_q;
    logic [7:0]       mem_q [256];
    logic [7:0]       fifo_q [OFIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    logic       run, io_sel, ld_acc, ld_done;
    logic       ram_we, push_req, push, pop, drop;
    logic       fifo_empty, fifo_full;
    logic [7:0] status;

    assign run        = (state_q == S_RUN);
    assign io_sel     = (bus.addr == IO_ADDR);
    assign ld_acc     = (state_q == S_LOAD) && ld_ready_q && bus.ld_valid;
    assign ld_done    = ld_acc && (bus.ld_last || ptr_q == 8'hFF);
    assign ram_we     = run && bus.we && !io_sel;
    assign push_req   = run && bus.we && io_sel;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == DEPTH_C);
    assign pop        = !fifo_empty && bus.out_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign status     = {ovf_q, 5'b0, fifo_full, fifo_empty};

    assign bus.rdata     = rdata_q;
    assign bus.cpu_en    = run;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
    assign bus.ovf       = ovf_q;

    // Control state register: load/run phase, load pointer, loader ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            ptr_q      <= 8'h00;
            ld_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ld_ready_q <= ld_ready_d;
        end
    end

    // Next-state logic: accept loader bytes until ld_last or the top address.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ld_ready_d = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld_ready_d = 1'b1;
                if (ld_acc) ptr_d = ptr_q + 8'd1;
                if (ld_done) begin
                    state_d    = S_RUN;
                    ld_ready_d = 1'b0;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_LOAD;
        endcase
    end

    // RAM write port: loader bytes in LOAD, CPU stores outside the IO address in RUN.
    always_ff @(posedge clk) begin
        if (ld_acc)      mem_q[ptr_q]    <= bus.ld_data;
        else if (ram_we) mem_q[bus.addr] <= bus.wdata;
    end

    // Registered read port; old contents on read-during-write, held at zero while loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rdata_q <= 8'h00;
        else if (run) rdata_q <= io_sel ? status : mem_q[bus.addr];
        else          rdata_q <= 8'h00;
    end

    // FIFO storage: written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= bus.wdata;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop) ovf_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eightbit_mem.sv
// Bench for eightbit_mem: directed scenarios plus randomized run-phase
// traffic, all checked cycle by cycle against a behavioural model.
module tb_eightbit_mem;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;

    eightbit_mem_if bus ();

    eightbit_mem #(.IO_ADDR(8'hFF), .OFIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    logic [7:0]  m_mem [256];
    byte unsigned q [$];
    bit          m_run, m_ldrdy, m_ovf;
    logic [7:0]  m_rdata;
    int          m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("rdata",     32'(bus.rdata),     32'(m_rdata));
        chk("cpu_en",    32'(bus.cpu_en),    32'(m_run));
        chk("ld_ready",  32'(bus.ld_ready),  32'(m_ldrdy));
        chk("out_valid", 32'(bus.out_valid), (q.size() != 0) ? 32'd1 : 32'd0);
        chk("out_data",  32'(bus.out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk("ovf",       32'(bus.ovf),       32'(m_ovf));
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_ldrdy = 1'b0;
        m_ovf   = 1'b0;
        m_rdata = 8'h00;
        m_ptr   = 0;
        q.delete();
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT and compare.
    task automatic cycle();
        bit         pop;
        logic [7:0] st;
        pop = (q.size() != 0) && bus.out_ready;
        if (!m_run) begin
            m_rdata = 8'h00;
            if (pop) void'(q.pop_front());
            if (bus.ld_valid && m_ldrdy) begin
                m_mem[m_ptr] = bus.ld_data;
                if (bus.ld_last || m_ptr == 255) begin
                    m_run   = 1'b1;
                    m_ldrdy = 1'b0;
                end else begin
                    m_ptr++;
                    m_ldrdy = 1'b1;
                end
            end else begin
                m_ldrdy = 1'b1;
            end
        end else begin
            st = {m_ovf, 5'b0, q.size() == D, q.size() == 0};
            m_rdata = (bus.addr == 8'hFF) ? st : m_mem[bus.addr];
            if (pop) void'(q.pop_front());
            if (bus.we) begin
                if (bus.addr != 8'hFF)   m_mem[bus.addr] = bus.wdata;
                else if (q.size() < D)   q.push_back(bus.wdata);
                else                     m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.addr = 8'h00; bus.wdata = 8'h00; bus.we = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = 8'h00; bus.ld_last = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Asynchronous reset raised between edges; outputs must fall before any clock.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_rdata",     32'(bus.rdata),     32'd0);
        chk("rst_cpu_en",    32'(bus.cpu_en),    32'd0);
        chk("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] d, input bit last);
        bit acc;
        acc = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = bus.ld_ready;
            cycle();
        end
        if (!acc) chk("ld_timeout", 32'd0, 32'd1);
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic read_addr(input logic [7:0] a);
        bus.addr = a;
        bus.we   = 1'b0;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Short program with ld_last on the third byte
        load_byte(8'h41, 1'b0);
        load_byte(8'h42, 1'b0);
        load_byte(8'h43, 1'b1);
        chk("t1_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("t1_cpu_en",   32'(bus.cpu_en),   32'd1);
        read_addr(8'h00); chk("t1_rd0", 32'(bus.rdata), 32'h41);
        read_addr(8'h01); chk("t1_rd1", 32'(bus.rdata), 32'h42);
        read_addr(8'h02); chk("t1_rd2", 32'(bus.rdata), 32'h43);

        // Full 256-byte image without ld_last
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            load_byte(8'(i), 1'b0);
            if (i == 254) chk("t2_not_run_yet", 32'(bus.cpu_en), 32'd0);
        end
        chk("t2_cpu_en", 32'(bus.cpu_en), 32'd1);
        read_addr(8'h10); chk("t2_rd10",    32'(bus.rdata), 32'h10);
        read_addr(8'hFF); chk("t2_rd_stat", 32'(bus.rdata), 32'h01);

        // Read-during-write returns old contents
        bus.addr = 8'h20; bus.wdata = 8'h5A; bus.we = 1'b1;
        cycle();
        chk("t3_old", 32'(bus.rdata), 32'h20);
        bus.we = 1'b0;
        cycle();
        chk("t3_new", 32'(bus.rdata), 32'h5A);

        // Overflow on the fifth IO write, then drain in order
        bus.out_ready = 1'b0;
        bus.addr = 8'hFF;
        for (int v = 1; v <= 5; v++) begin
            bus.wdata = 8'(v); bus.we = 1'b1;
            cycle();
        end
        bus.we = 1'b0;
        chk("t4_ovf", 32'(bus.ovf), 32'd1);
        read_addr(8'hFF); chk("t4_stat", 32'(bus.rdata), 32'h82);
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            chk("t4_head", {23'd0, bus.out_valid, bus.out_data}, {23'd0, 1'b1, 8'(v)});
            cycle();
        end
        chk("t4_empty", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        apply_reset();
        load_byte(8'h99, 1'b1);
        bus.addr = 8'hFF;
        for (int v = 1; v <= 4; v++) begin
            bus.wdata = 8'(v); bus.we = 1'b1;
            cycle();
        end
        bus.wdata = 8'h77; bus.out_ready = 1'b1;
        cycle();
        bus.we = 1'b0; bus.out_ready = 1'b0;
        chk("t5_ovf", 32'(bus.ovf), 32'd0);
        read_addr(8'hFF); chk("t5_stat", 32'(bus.rdata), 32'h02);
        chk("t5_head", 32'(bus.out_data), 32'h02);

        // Reset in RUN with a loaded FIFO and non-zero rdata
        apply_reset();

        // Reset mid-load, then reload a single byte
        load_byte(8'hAA, 1'b0);
        load_byte(8'hBB, 1'b0);
        chk("t6_ld_ready_pre", 32'(bus.ld_ready), 32'd1);
        apply_reset();
        load_byte(8'hCC, 1'b1);
        read_addr(8'h00); chk("t6_rd0", 32'(bus.rdata), 32'hCC);
        read_addr(8'h01); chk("t6_rd1", 32'(bus.rdata), 32'hBB);

        // Randomized run-phase traffic
        for (int n = 0; n < 400; n++) begin
            bus.addr      = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            bus.we        = 1'($urandom_range(0, 1));
            bus.wdata     = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
